text_writer: RTL and testbench
==============================

Name: text_writer

Overview:
- Terminal-style writer that fills the character buffer; the glyph renderer later reads this buffer to produce pixels.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor.
- Writes printable characters into the buffer's write port, honours a small set of control codes, and blanks rows as the cursor advances.
- Default screen is 80x30 cells: 640x480 pixels with an 8x16 font.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_WIDTH, 12, buffer address width; COLS*ROWS must be <= 2^ADDR_WIDTH.
- BLANK, 8'h20, fill character used by all clears.

Ports:
- px_clk  in  1  pixel clock; the single clock of the block.
- resetn  in  1  asynchronous, active-low reset.
- char_valid  in  1  char_data is presented.
- char_data  in  8  character code.
- char_ready  out  1  block can accept a character.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_WIDTH  buffer address, equal to y*COLS+x.
- wr_data  out  8  byte to write.
- cursor_x  out  7  current column, 0..COLS-1.
- cursor_y  out  5  current row, 0..ROWS-1.
- busy  out  1  a clear is in progress.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - wr_en=0, wr_addr=0, wr_data=0, cursor=(0,0).
  - state=CLEAR_ALL, clear counter=0.
  - char_ready=0, busy=1.
- Assertion mid-operation aborts any clear or pending write immediately. Nothing is written while resetn=0.
- States: CLEAR_ALL, CLEAR_LINE, IDLE.
- char_ready is combinational, equal to (state==IDLE). busy is equal to (state!=IDLE).
- A handshake occurs on a px_clk edge where char_valid=1 and char_ready=1. Data is ignored when char_ready=0. The source must hold char_valid and char_data until the handshake.
- All write-port outputs are registered. wr_en is high for exactly the cycles listed below and low otherwise. wr_addr and wr_data hold their last values when wr_en=0.
- Row addressing:
  - The row base is a register holding cursor_y*COLS.
  - It is maintained by adding COLS, or resetting to 0. No multiplier is used.
- CLEAR_ALL:
  - Each cycle drives wr_en=1, wr_addr=cnt, wr_data=BLANK.
  - After the write of address COLS*ROWS-1 (2400 writes by default), go to IDLE with cursor=(0,0).
- IDLE, on a handshake, by char_data:
  - 0x20..0x7E and 0x80..0xFF (printable):
    - Next edge: wr_en=1, wr_addr=base+x, wr_data=char.
    - If x<COLS-1: x+1, stay IDLE.
    - If x=COLS-1: x=0, advance row, go to CLEAR_LINE.
  - 0x0D (CR): x=0, no write, stay IDLE.
  - 0x0A (LF): x=0, advance row, go to CLEAR_LINE, no write.
  - 0x08 (BS): if x>0 then x-1, otherwise no change. No write.
  - 0x0C (FF): go to CLEAR_ALL with cnt=0.
  - Other codes 0x00..0x1F and 0x7F: ignored. No write and no cursor change, but still consumed.
- Advance row:
  - If y<ROWS-1: y+1, base+COLS.
  - If y=ROWS-1: wrap to y=0, base=0.
- CLEAR_LINE:
  - Starts the cycle after the triggering handshake.
  - Runs COLS cycles, each with wr_en=1, wr_addr=base+cnt, wr_data=BLANK. base is the new row's base.
  - Then returns to IDLE. Cursor stays at (0,new y).
- Cursor outputs update on the handshake edge, the same edge that drives the character write.
- No character is accepted on the final clear cycle. char_ready rises the cycle after the last clear write.

Test Plan:
- Release resetn -> 2400 consecutive cycles with wr_en=1 and wr_data=8'h20, addresses 0..2399 in order. Then char_ready=1, cursor=(0,0).
- After clear, send 'A' (0x41) then 'B' -> writes (0,0x41) and (1,0x42) on consecutive accepted beats, cursor_x=2. 'A' and 'B' are the ASCII letters.
- 80 printable bytes at cursor (0,0) -> last write lands at addr 79. The next 80 cycles write 0x20 to addrs 80..159 with char_ready=0. Cursor ends at (0,1).
- With cursor at (5,29):
  - Send 0x0A -> 80 blank writes to addrs 0..79, cursor=(0,0).
  - Send 0x08 at x=0 -> no write, cursor unchanged.
- Stream 'H', 0x08, 'J' -> writes 'H' at 0, then 'J' at 0. Send 0x0D -> cursor_x=0 with no write. Send 0x07 -> accepted with no write.
- Pulse resetn low mid-CLEAR_LINE -> wr_en drops immediately. After release, a full CLEAR_ALL restarts from addr 0.

Source files
------------

// File: rtl/text_writer.sv
// Terminal-style writer: consumes a byte stream, tracks a cursor and fills the
// character buffer, blanking the whole screen or the next row as needed.
module text_writer #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic                  px_clk,
    input  logic                  resetn,
    input  logic                  char_valid,
    input  logic [7:0]            char_data,
    output logic                  char_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic [6:0]            cursor_x,
    output logic [4:0]            cursor_y,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StClearAll,
        StClearLine,
        StIdle
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr    = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] RowStep     = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LastLineCnt = ADDR_WIDTH'(COLS - 1);
    localparam logic [6:0]            LastCol     = 7'(COLS - 1);
    localparam logic [4:0]            LastRow     = 5'(ROWS - 1);

    localparam logic [7:0] ChCr  = 8'h0D;
    localparam logic [7:0] ChLf  = 8'h0A;
    localparam logic [7:0] ChBs  = 8'h08;
    localparam logic [7:0] ChFf  = 8'h0C;
    localparam logic [7:0] ChDel = 8'h7F;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [6:0]            x_q, x_d;
    logic [4:0]            y_q, y_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;

    logic                  handshake;
    logic                  printable;
    logic [4:0]            y_adv;
    logic [ADDR_WIDTH-1:0] base_adv;

    assign handshake = char_valid && (state_q == StIdle);
    assign printable = (char_data >= 8'h20) && (char_data != ChDel);

    // Row base tracks y*COLS incrementally so no multiplier is needed.
    always_comb begin
        if (y_q == LastRow) begin
            y_adv    = '0;
            base_adv = '0;
        end else begin
            y_adv    = y_q + 5'd1;
            base_adv = base_q + RowStep;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        x_d       = x_q;
        y_d       = y_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StClearAll: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = BLANK;
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StClearLine: begin
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + cnt_q;
                wr_data_d = BLANK;
                if (cnt_q == LastLineCnt) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StIdle: begin
                cnt_d = '0;
                if (handshake) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + ADDR_WIDTH'(x_q);
                        wr_data_d = char_data;
                        if (x_q == LastCol) begin
                            x_d     = '0;
                            y_d     = y_adv;
                            base_d  = base_adv;
                            state_d = StClearLine;
                        end else begin
                            x_d = x_q + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            ChCr: x_d = '0;
                            ChLf: begin
                                x_d     = '0;
                                y_d     = y_adv;
                                base_d  = base_adv;
                                state_d = StClearLine;
                            end
                            ChBs: begin
                                if (x_q != '0) begin
                                    x_d = x_q - 7'd1;
                                end
                            end
                            ChFf:    state_d = StClearAll;
                            default: ;
                        endcase
                    end
                end
            end

            default: begin
                state_d = StClearAll;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge px_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StClearAll;
            cnt_q     <= '0;
            base_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign char_ready = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_x   = x_q;
    assign cursor_y   = y_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: stimulus queues expected buffer writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_text_writer;

    logic        px_clk = 1'b0;
    logic        resetn;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];

    text_writer #(
        .COLS       (80),
        .ROWS       (30),
        .ADDR_WIDTH (12),
        .BLANK      (8'h20)
    ) dut (
        .px_clk     (px_clk),
        .resetn     (resetn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    always #5 px_clk = ~px_clk;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge px_clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t e;
        e.addr = 12'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_blank(input int base, input int n);
        for (int i = 0; i < n; i++) push_wr(base + i, 8'h20);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge px_clk);
        char_valid = 1'b1;
        char_data  = c;
        while (char_ready !== 1'b1 && n < 5000) begin
            @(negedge px_clk);
            n++;
        end
        if (n >= 5000) begin
            check("send_timeout", 32'(n), 0);
        end else begin
            @(posedge px_clk);
        end
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge px_clk);
            #1;
            n++;
        end while (!(char_ready === 1'b1 && exp_q.size() == 0) && n < budget);
        check({name, "_drain"}, 32'(exp_q.size()), 0);
        check({name, "_ready"}, 32'(char_ready), 1);
    endtask

    initial begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        resetn     = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_ready", 32'(char_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_cursor", {cursor_y, cursor_x}, 0);

        // Power-up clear of all 2400 cells.
        push_blank(0, 2400);
        repeat (2) @(negedge px_clk);
        resetn = 1'b1;
        repeat (5) @(negedge px_clk);
        #1;
        check("clr_ready_low", 32'(char_ready), 0);
        check("clr_busy", 32'(busy), 1);
        wait_idle("clear_all", 3000);
        check("clr_cursor", {cursor_y, cursor_x}, 0);

        // 'A' then 'B'.
        push_wr(0, 8'h41);
        push_wr(1, 8'h42);
        send(8'h41);
        check("a_cursor_x", 32'(cursor_x), 1);
        send(8'h42);
        wait_idle("ab", 20);
        check("ab_cursor_x", 32'(cursor_x), 2);
        check("ab_cursor_y", 32'(cursor_y), 0);

        // CR back to column 0, then a full row including high-half codes.
        send(8'h0D);
        check("cr_cursor_x", 32'(cursor_x), 0);
        for (int i = 0; i < 80; i++) begin
            logic [7:0] c;
            c = (i < 40) ? 8'(8'h21 + i) : 8'(8'h80 + i);
            push_wr(i, c);
        end
        push_blank(80, 80);
        for (int i = 0; i < 80; i++) begin
            send((i < 40) ? 8'(8'h21 + i) : 8'(8'h80 + i));
        end
        check("wrap_ready_low", 32'(char_ready), 0);
        check("wrap_busy", 32'(busy), 1);
        check("wrap_cursor", {cursor_y, cursor_x}, {5'd1, 7'd0});
        wait_idle("row_wrap", 200);
        check("wrap_cursor_end", {cursor_y, cursor_x}, {5'd1, 7'd0});

        // Walk down to row 29 with LFs, then place the cursor at (5,29).
        for (int r = 2; r < 30; r++) begin
            push_blank(r * 80, 80);
            send(8'h0A);
        end
        wait_idle("lf_walk", 3000);
        check("lf_walk_y", 32'(cursor_y), 29);
        for (int i = 0; i < 5; i++) begin
            push_wr(29 * 80 + i, 8'(8'h61 + i));
            send(8'(8'h61 + i));
        end
        wait_idle("row29", 20);
        check("row29_cursor", {cursor_y, cursor_x}, {5'd29, 7'd5});

        // LF on the last row wraps to row 0 and blanks it.
        push_blank(0, 80);
        send(8'h0A);
        wait_idle("lf_wrap", 200);
        check("lf_wrap_cursor", {cursor_y, cursor_x}, 0);

        // BS at column 0 does nothing.
        send(8'h08);
        wait_idle("bs_x0", 5);
        check("bs_x0_cursor", {cursor_y, cursor_x}, 0);

        // 'H', BS, 'J' overwrite the same cell.
        push_wr(0, 8'h48);
        push_wr(0, 8'h4A);
        send(8'h48);
        send(8'h08);
        check("bs_cursor_x", 32'(cursor_x), 0);
        send(8'h4A);
        wait_idle("hbj", 20);
        check("hbj_cursor_x", 32'(cursor_x), 1);
        send(8'h0D);
        wait_idle("cr", 5);
        check("cr2_cursor_x", 32'(cursor_x), 0);
        send(8'h07);
        wait_idle("bel", 5);
        check("bel_cursor", {cursor_y, cursor_x}, 0);
        send(8'h7F);
        wait_idle("del", 5);
        check("del_cursor", {cursor_y, cursor_x}, 0);

        // FF restarts the full-screen clear.
        push_blank(0, 2400);
        send(8'h0C);
        check("ff_busy", 32'(busy), 1);
        wait_idle("ff", 3000);
        check("ff_cursor", {cursor_y, cursor_x}, 0);

        // Reset in the middle of a line clear.
        push_blank(80, 80);
        send(8'h0A);
        repeat (10) @(negedge px_clk);
        #1;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_busy", 32'(busy), 1);
        check("midrst_cursor", {cursor_y, cursor_x}, 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        repeat (3) @(negedge px_clk);
        push_blank(0, 2400);
        resetn = 1'b1;
        wait_idle("rst_clear", 3000);
        check("rst_clear_cursor", {cursor_y, cursor_x}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
